cpu_io_fifo: RTL and testbench

//   Parametrised, buffered I/O channel between the cpu and its environment (bench or peripheral).

---
 rtl/cpu_io_pkg.sv | 20 ++
 rtl/cpu_io_fifo_if.sv | 32 +++
 rtl/cpu_io_fifo_ptr.sv | 26 ++
 rtl/cpu_io_fifo.sv | 99 +++++++++
 tb/tb_cpu_io_fifo.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_io_pkg.sv
// Shared constants, pointer-width helper and FIFO status type for the cpu I/O channels.
package cpu_io_pkg;

  localparam int CPU_DATA_WIDTH = 16;
  localparam int CPU_ADDR_WIDTH = 6;

  // Status count field is sized for the largest supported depth (128 entries).
  localparam int STATUS_CNT_W = 8;

  typedef struct packed {
    logic [STATUS_CNT_W-1:0] count;
    logic                    full;
    logic                    empty;
  } fifo_status_t;

  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/cpu_io_fifo_if.sv
// Producer/consumer bundle of one cpu I/O FIFO; master = environment side, slave = FIFO.
interface cpu_io_fifo_if #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4
);

  localparam int CNT_W = cpu_io_pkg::ptr_width(DEPTH) + 1;

  logic                  wr_valid;
  logic                  wr_ready;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_pop;
  logic                  rd_valid;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [CNT_W-1:0]      count;
  logic                  full;
  logic                  empty;
  logic                  err_clr;
  logic                  err_ovf;
  logic                  err_udf;

  modport master (
    output wr_valid, wr_data, rd_pop, err_clr,
    input  wr_ready, rd_valid, rd_data, count, full, empty, err_ovf, err_udf
  );

  modport slave (
    input  wr_valid, wr_data, rd_pop, err_clr,
    output wr_ready, rd_valid, rd_data, count, full, empty, err_ovf, err_udf
  );

endinterface

// File: rtl/cpu_io_fifo_ptr.sv
// Extended FIFO pointer: PTR_W index bits plus one wrap bit, advanced by inc.
module fifo_ptr #(
  parameter int PTR_W = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           inc,
  output logic [PTR_W:0] ptr
);

  logic [PTR_W:0] ptr_r;

  // Pointer register; wraps naturally modulo 2*DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= {(PTR_W+1){1'b0}};
    end else if (inc) begin
      ptr_r <= ptr_r + {{PTR_W{1'b0}}, 1'b1};
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign ptr = ptr_r;

endmodule

// File: rtl/cpu_io_fifo.sv
// First-word-fall-through cpu I/O FIFO with valid/ready push and pop-strobe read.
// Sticky overflow/underflow flags are built only when CPU_IO_FIFO_ERR_EN is defined.
module cpu_io_fifo
  import cpu_io_pkg::*;
#(
  parameter int DATA_WIDTH = CPU_DATA_WIDTH,
  parameter int DEPTH      = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  cpu_io_fifo_if.slave bus
);

  localparam int PTR_W = ptr_width(DEPTH);

  logic [PTR_W:0]        wr_ptr_s;
  logic [PTR_W:0]        rd_ptr_s;
  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic                  push_s;
  logic                  pop_s;
  fifo_status_t          status_s;

  fifo_ptr #(.PTR_W(PTR_W)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (push_s),
    .ptr   (wr_ptr_s)
  );

  fifo_ptr #(.PTR_W(PTR_W)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (pop_s),
    .ptr   (rd_ptr_s)
  );

  // Status depends on pointers only, so no path runs from wr_valid/rd_pop to it.
  always_comb begin
    status_s       = '0;
    status_s.empty = (wr_ptr_s == rd_ptr_s);
    status_s.full  = (wr_ptr_s[PTR_W] != rd_ptr_s[PTR_W]) &&
                     (wr_ptr_s[PTR_W-1:0] == rd_ptr_s[PTR_W-1:0]);
    status_s.count = STATUS_CNT_W'(wr_ptr_s - rd_ptr_s);
  end

  assign push_s = bus.wr_valid & ~status_s.full;
  assign pop_s  = bus.rd_pop & ~status_s.empty;

  // Storage write; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_s[PTR_W-1:0]] <= bus.wr_data;
    end
  end

  assign bus.rd_data  = status_s.empty ? {DATA_WIDTH{1'b0}} : mem_r[rd_ptr_s[PTR_W-1:0]];
  assign bus.count    = status_s.count[PTR_W:0];
  assign bus.full     = status_s.full;
  assign bus.empty    = status_s.empty;
  assign bus.wr_ready = ~status_s.full;
  assign bus.rd_valid = ~status_s.empty;

`ifdef CPU_IO_FIFO_ERR_EN
  logic err_ovf_r;
  logic err_udf_r;

  // Sticky error flags; a new error in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_ovf_r <= 1'b0;
      err_udf_r <= 1'b0;
    end else begin
      if (bus.wr_valid & status_s.full) begin
        err_ovf_r <= 1'b1;
      end else if (bus.err_clr) begin
        err_ovf_r <= 1'b0;
      end else begin
        err_ovf_r <= err_ovf_r;
      end
      if (bus.rd_pop & status_s.empty) begin
        err_udf_r <= 1'b1;
      end else if (bus.err_clr) begin
        err_udf_r <= 1'b0;
      end else begin
        err_udf_r <= err_udf_r;
      end
    end
  end

  assign bus.err_ovf = err_ovf_r;
  assign bus.err_udf = err_udf_r;
`else
  logic unused_err_clr_s;
  assign unused_err_clr_s = bus.err_clr;
  assign bus.err_ovf      = 1'b0;
  assign bus.err_udf      = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_io_fifo.sv
// Directed self-checking bench for cpu_io_fifo (DEPTH=4, DATA_WIDTH=16).
module tb_cpu_io_fifo;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

`ifdef CPU_IO_FIFO_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  cpu_io_fifo_if #(.DATA_WIDTH(16), .DEPTH(4)) bus ();

  cpu_io_fifo #(.DATA_WIDTH(16), .DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr_valid = 1'b0;
    bus.wr_data  = 16'h0000;
    bus.rd_pop   = 1'b0;
    bus.err_clr  = 1'b0;
  endtask

  task automatic push(input logic [15:0] d);
    bus.wr_valid = 1'b1;
    bus.wr_data  = d;
    step();
    bus.wr_valid = 1'b0;
  endtask

  task automatic pop();
    bus.rd_pop = 1'b1;
    step();
    bus.rd_pop = 1'b0;
  endtask

  task automatic test_reset();
    n_tests++;
    if (bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.wr_ready !== 1'b1 || bus.rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got empty=%b full=%b wr_ready=%b rd_valid=%b expected 1 0 1 0",
               bus.empty, bus.full, bus.wr_ready, bus.rd_valid);
    end
    n_tests++;
    if (bus.count !== 3'd0 || bus.rd_data !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_count_data: got count=%0d rd_data=%h expected 0 0000", bus.count, bus.rd_data);
    end
    n_tests++;
    if (bus.err_ovf !== 1'b0 || bus.err_udf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_err: got ovf=%b udf=%b expected 0 0", bus.err_ovf, bus.err_udf);
    end
  endtask

  task automatic test_single();
    push(16'h0009);
    n_tests++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== 16'h0009 || bus.count !== 3'd1) begin
      n_fail++;
      $display("FAIL single_push: got rd_valid=%b rd_data=%h count=%0d expected 1 0009 1",
               bus.rd_valid, bus.rd_data, bus.count);
    end
    pop();
    n_tests++;
    if (bus.empty !== 1'b1 || bus.rd_data !== 16'h0000) begin
      n_fail++;
      $display("FAIL single_pop: got empty=%b rd_data=%h expected 1 0000", bus.empty, bus.rd_data);
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 4; i++) push(16'(i));
    n_tests++;
    if (bus.full !== 1'b1 || bus.wr_ready !== 1'b0 || bus.count !== 3'd4) begin
      n_fail++;
      $display("FAIL fill_full: got full=%b wr_ready=%b count=%0d expected 1 0 4", bus.full, bus.wr_ready, bus.count);
    end
    push(16'h0005);
    n_tests++;
    if (bus.count !== 3'd4 || bus.rd_data !== 16'h0001) begin
      n_fail++;
      $display("FAIL push_when_full: got count=%0d head=%h expected 4 0001", bus.count, bus.rd_data);
    end
    for (int i = 1; i <= 4; i++) begin
      n_tests++;
      if (bus.rd_data !== 16'(i)) begin
        n_fail++;
        $display("FAIL drain_order: got %h expected %h", bus.rd_data, 16'(i));
      end
      pop();
    end
    n_tests++;
    if (bus.empty !== 1'b1 || bus.count !== 3'd0) begin
      n_fail++;
      $display("FAIL drain_empty: got empty=%b count=%0d expected 1 0", bus.empty, bus.count);
    end
  endtask

  task automatic test_push_pop();
    for (int i = 0; i < 4; i++) push(16'h0010 + 16'(i));
    bus.wr_valid = 1'b1; bus.wr_data = 16'h0099; bus.rd_pop = 1'b1;
    step();
    bus.wr_valid = 1'b0; bus.rd_pop = 1'b0;
    n_tests++;
    if (bus.count !== 3'd3 || bus.rd_data !== 16'h0011) begin
      n_fail++;
      $display("FAIL full_push_pop: got count=%0d head=%h expected 3 0011", bus.count, bus.rd_data);
    end
    pop();
    bus.wr_valid = 1'b1; bus.wr_data = 16'h0020; bus.rd_pop = 1'b1;
    step();
    bus.wr_valid = 1'b0; bus.rd_pop = 1'b0;
    n_tests++;
    if (bus.count !== 3'd2 || bus.rd_data !== 16'h0013) begin
      n_fail++;
      $display("FAIL mid_push_pop: got count=%0d head=%h expected 2 0013", bus.count, bus.rd_data);
    end
    pop();
    n_tests++;
    if (bus.rd_data !== 16'h0020 || bus.count !== 3'd1) begin
      n_fail++;
      $display("FAIL push_pop_order: got head=%h count=%0d expected 0020 1", bus.rd_data, bus.count);
    end
    pop();
    bus.wr_valid = 1'b1; bus.wr_data = 16'h0007; bus.rd_pop = 1'b1;
    step();
    bus.wr_valid = 1'b0; bus.rd_pop = 1'b0;
    n_tests++;
    if (bus.count !== 3'd1 || bus.rd_data !== 16'h0007) begin
      n_fail++;
      $display("FAIL empty_push_pop: got count=%0d head=%h expected 1 0007", bus.count, bus.rd_data);
    end
    pop();
  endtask

  task automatic test_wrap();
    for (int c = 0; c < 10; c++) begin
      for (int i = 0; i < 4; i++) push(16'h0100 * 16'(c) + 16'(i));
      n_tests++;
      if (bus.count !== 3'd4 || bus.full !== 1'b1) begin
        n_fail++;
        $display("FAIL wrap_fill c=%0d: got count=%0d full=%b expected 4 1", c, bus.count, bus.full);
      end
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (bus.rd_data !== 16'h0100 * 16'(c) + 16'(i)) begin
          n_fail++;
          $display("FAIL wrap_data c=%0d i=%0d: got %h expected %h", c, i, bus.rd_data, 16'h0100 * 16'(c) + 16'(i));
        end
        pop();
      end
    end
    n_tests++;
    if (bus.empty !== 1'b1 || bus.rd_data !== 16'h0000) begin
      n_fail++;
      $display("FAIL wrap_end: got empty=%b rd_data=%h expected 1 0000", bus.empty, bus.rd_data);
    end
  endtask

  task automatic test_err();
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;
    n_tests++;
    if (bus.err_ovf !== 1'b0 || bus.err_udf !== 1'b0) begin
      n_fail++;
      $display("FAIL err_initial_clear: got ovf=%b udf=%b expected 0 0", bus.err_ovf, bus.err_udf);
    end
    pop();
    n_tests++;
    if (bus.err_udf !== ERR_EXP || bus.err_ovf !== 1'b0 || bus.count !== 3'd0) begin
      n_fail++;
      $display("FAIL err_udf: got udf=%b ovf=%b count=%0d expected %b 0 0", bus.err_udf, bus.err_ovf, bus.count, ERR_EXP);
    end
    for (int i = 0; i < 4; i++) push(16'h0a00 + 16'(i));
    push(16'hdead);
    step();
    n_tests++;
    if (bus.err_ovf !== ERR_EXP || bus.err_udf !== ERR_EXP || bus.count !== 3'd4) begin
      n_fail++;
      $display("FAIL err_ovf_hold: got ovf=%b udf=%b count=%0d expected %b %b 4",
               bus.err_ovf, bus.err_udf, bus.count, ERR_EXP, ERR_EXP);
    end
    bus.wr_valid = 1'b1; bus.wr_data = 16'hbad0; bus.err_clr = 1'b1;
    step();
    bus.wr_valid = 1'b0; bus.err_clr = 1'b0;
    n_tests++;
    if (bus.err_ovf !== ERR_EXP || bus.err_udf !== 1'b0) begin
      n_fail++;
      $display("FAIL err_set_wins: got ovf=%b udf=%b expected %b 0", bus.err_ovf, bus.err_udf, ERR_EXP);
    end
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;
    n_tests++;
    if (bus.err_ovf !== 1'b0 || bus.err_udf !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear: got ovf=%b udf=%b expected 0 0", bus.err_ovf, bus.err_udf);
    end
    for (int i = 0; i < 4; i++) pop();
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) push(16'h0300 + 16'(i));
    #3;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.empty !== 1'b1 || bus.count !== 3'd0 || bus.rd_data !== 16'h0000) begin
      n_fail++;
      $display("FAIL async_reset: got empty=%b count=%0d rd_data=%h expected 1 0 0000", bus.empty, bus.count, bus.rd_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    push(16'hbeef);
    n_tests++;
    if (bus.rd_data !== 16'hbeef || bus.count !== 3'd1) begin
      n_fail++;
      $display("FAIL post_reset_push: got rd_data=%h count=%0d expected beef 1", bus.rd_data, bus.count);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_single();
    test_fill_drain();
    test_push_pop();
    test_wrap();
    test_err();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
